dense_layer_seq: RTL

//  Parametrised, time-multiplexed fully-connected layer for the GAN datapath.

---
 rtl/dense_layer_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dense_layer_seq.sv
// dense_layer_seq -- time-multiplexed fully-connected layer.
// One signed multiplier and one wide accumulator are shared by all neurons:
// each neuron takes N_IN MAC cycles plus one BIAS cycle, so a result appears
// N_OUT*(N_IN+1) cycles after an input vector is accepted.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   in_valid      in_vec valid
//   in_ready      high only when idle; in_vec is latched on in_valid&&in_ready
//   in_vec        N_IN signed words, element k at [DATA_W*k +: DATA_W]
//   flat_weights  per neuron n: N_IN weights then a bias, slot j at
//                 [DATA_W*(n*(N_IN+1)+j) +: DATA_W]; read live, must be held
//                 stable by the source for the whole transaction
//   out_valid     result valid, held until out_ready
//   out_ready     downstream accepts result
//   out_vec       N_OUT signed words, neuron n at [DATA_W*n +: DATA_W]
//   sat_flag      at least one neuron overflowed DATA_W in this result
//   busy          high while computing (MAC/BIAS)
module dense_layer_seq #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 9,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACT    = 2   // 0 linear, 1 ReLU, 2 hard-tanh
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N_IN*DATA_W-1:0]           in_vec,
  input  logic [N_OUT*(N_IN+1)*DATA_W-1:0] flat_weights,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N_OUT*DATA_W-1:0]          out_vec,
  output logic                             sat_flag,
  output logic                             busy
);

  localparam int ACC_W = 2*DATA_W + $clog2(N_IN+1) + 1;
  localparam int PW    = 2*DATA_W;
  localparam int KW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int NW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1) << FRAC;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_BIAS, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [KW-1:0]             k_q, k_d;
  logic [NW-1:0]             n_q, n_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [N_IN*DATA_W-1:0]    x_q, x_d;
  logic [N_OUT*DATA_W-1:0]   out_q, out_d;
  logic                      sticky_q, sticky_d;
  logic                      sat_q, sat_d;

  int unsigned               slot;
  logic signed [DATA_W-1:0]  x_k, w_k, bias_n;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   prod_ext, bias_ext, sum, shifted;
  logic signed [DATA_W-1:0]  sat_val, act_val;
  logic                      clip;

  // Operand selection for the current neuron / input index.
  always_comb begin
    slot   = 32'(n_q) * 32'(N_IN+1);
    x_k    = x_q[DATA_W*k_q +: DATA_W];
    w_k    = flat_weights[DATA_W*(slot + 32'(k_q)) +: DATA_W];
    bias_n = flat_weights[DATA_W*(slot + 32'(N_IN)) +: DATA_W];
  end

  // Datapath: full-width product, bias aligned to the product's binary point,
  // floor shift back to Q format, DATA_W saturation, then activation.
  always_comb begin
    prod     = x_k * w_k;
    prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
    bias_ext = {{(ACC_W-DATA_W){bias_n[DATA_W-1]}}, bias_n} <<< FRAC;
    sum      = acc_q + bias_ext;
    shifted  = sum >>> FRAC;

    clip    = 1'b0;
    sat_val = shifted[DATA_W-1:0];
    if (shifted > SMAX) begin
      sat_val = SMAX[DATA_W-1:0];
      clip    = 1'b1;
    end else if (shifted < SMIN) begin
      sat_val = SMIN[DATA_W-1:0];
      clip    = 1'b1;
    end

    // Activation clipping never contributes to sat_flag.
    act_val = sat_val;
    if (ACT == 1) begin
      if (sat_val < 0) act_val = '0;
    end else if (ACT == 2) begin
      if (sat_val > ONE)       act_val = ONE;
      else if (sat_val < -ONE) act_val = -ONE;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    n_d      = n_q;
    acc_d    = acc_q;
    x_d      = x_q;
    out_d    = out_q;
    sticky_d = sticky_q;
    sat_d    = sat_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d      = in_vec;
          n_d      = '0;
          k_d      = '0;
          acc_d    = '0;
          sticky_d = 1'b0;
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        if (k_q == KW'(N_IN-1)) state_d = S_BIAS;
        else                    k_d     = k_q + KW'(1);
      end
      S_BIAS: begin
        out_d[DATA_W*n_q +: DATA_W] = act_val;
        acc_d    = '0;
        k_d      = '0;
        sticky_d = sticky_q | clip;
        if (n_q == NW'(N_OUT-1)) begin
          // sat_flag only changes together with the completed result.
          sat_d   = sticky_q | clip;
          state_d = S_DONE;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      out_q    <= '0;
      sticky_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      out_q    <= out_d;
      sticky_q <= sticky_d;
      sat_q    <= sat_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MAC) || (state_q == S_BIAS);
  assign out_vec   = out_q;
  assign sat_flag  = sat_q;

endmodule
